thingamajig_demux: RTL

- Inverse of the team's 3:1 select mux: one input beat, tagged with a 2-bit select, is routed to exactly one of three 4-bit output channels (a, b, c).
- Each output channel has a one-entry holding register and a valid/ready handshake.
- The block narrows the 6-bit input word to 4 bits, which is the inverse of the mux's zero-extension. It flags any non-zero upper bits and counts beats that carry the unused select code 2'b11.

---
 rtl/thingamajig_pkg.sv | 14 +
 rtl/thingamajig_hold_reg.sv | 34 +++
 rtl/thingamajig_demux.sv | 90 +++++++++
 3 files changed

// File: rtl/thingamajig_pkg.sv
// Shared constants for the thingamajig demux.
// Holds the route-select codes and the default data and counter widths.
package thingamajig_pkg;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_DROP = 2'b11;

  localparam int DW_IN  = 6;
  localparam int DW_OUT = 4;
  localparam int CNT_W  = 8;

endpackage

// File: rtl/thingamajig_hold_reg.sv
// One-entry valid/ready holding register for a single output channel.
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   load           write load_data this cycle (upstream already saw room)
//   load_data      word to hold
//   ready          downstream consumer accepts
//   valid, data    registered channel outputs
module thingamajig_hold_reg #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data
);

  // A load wins over a drain, so a coincident drain+load keeps valid high
  // and the channel sustains one beat per cycle. A plain drain keeps data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/thingamajig_demux.sv
// 1:3 demux: routes one tagged input beat to channel a, b or c, narrowing
// the word from DW_IN to DW_OUT bits. Select code 11 drops the beat and
// bumps a saturating counter.
// Ports:
//   clk, rst                    clock and asynchronous active-high reset
//   in_valid/in_ready/in_data   input handshake and word
//   in_sel                      00 a, 01 b, 10 c, 11 drop
//   {a,b,c}_valid/ready/data    output channel handshakes and words
//   trunc_err                   one-cycle pulse: a routed beat lost upper bits
//   drop_clr                    synchronous clear of drop_cnt (wins over a drop)
//   drop_cnt                    saturating count of dropped beats
module thingamajig_demux #(
  parameter int DW_IN  = thingamajig_pkg::DW_IN,
  parameter int DW_OUT = thingamajig_pkg::DW_OUT,
  parameter int CNT_W  = thingamajig_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW_IN-1:0]  in_data,
  input  logic [1:0]        in_sel,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DW_OUT-1:0] a_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [DW_OUT-1:0] b_data,
  output logic              c_valid,
  input  logic              c_ready,
  output logic [DW_OUT-1:0] c_data,
  output logic              trunc_err,
  input  logic              drop_clr,
  output logic [CNT_W-1:0]  drop_cnt
);

  import thingamajig_pkg::*;

  logic accept;
  logic load_a, load_b, load_c, drop_acc;
  logic upper_nz;

  // Only the addressed channel gates acceptance; drops are always taken.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      SEL_A:   in_ready = !a_valid || a_ready;
      SEL_B:   in_ready = !b_valid || b_ready;
      SEL_C:   in_ready = !c_valid || c_ready;
      default: in_ready = 1'b1;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign load_a   = accept && (in_sel == SEL_A);
  assign load_b   = accept && (in_sel == SEL_B);
  assign load_c   = accept && (in_sel == SEL_C);
  assign drop_acc = accept && (in_sel == SEL_DROP);
  assign upper_nz = |in_data[DW_IN-1:DW_OUT];

  thingamajig_hold_reg #(.DW(DW_OUT)) u_hold_a (
    .clk(clk), .rst(rst), .load(load_a), .load_data(in_data[DW_OUT-1:0]),
    .ready(a_ready), .valid(a_valid), .data(a_data)
  );

  thingamajig_hold_reg #(.DW(DW_OUT)) u_hold_b (
    .clk(clk), .rst(rst), .load(load_b), .load_data(in_data[DW_OUT-1:0]),
    .ready(b_ready), .valid(b_valid), .data(b_data)
  );

  thingamajig_hold_reg #(.DW(DW_OUT)) u_hold_c (
    .clk(clk), .rst(rst), .load(load_c), .load_data(in_data[DW_OUT-1:0]),
    .ready(c_ready), .valid(c_valid), .data(c_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trunc_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      // Dropped beats are never routed, so their upper bits do not matter.
      trunc_err <= (load_a || load_b || load_c) && upper_nz;
      if (drop_clr)
        drop_cnt <= '0;
      else if (drop_acc && (drop_cnt != {CNT_W{1'b1}}))
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule
